// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer
//   Circular trace buffer that captures every MMIO display write and lets the
//   debug switches browse the captured words by age (index 0 = newest).
//   Adds freeze, clear, wrap status and a saturating dropped-write counter.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   wea, din    write strobe / data from the MMIO bus adapter
//   clr         synchronous clear of pointers, count, offset and status
//   freeze      while high, writes are counted as dropped instead of stored
//   sel         age index from the debug switches
//   step_up/dn  single-cycle pulses moving the view offset +1 / -1
//   dout        registered entry at view_idx (0 when not valid)
//   dout_valid  registered: view_idx < count
//   view_idx    (sel + offset) mod DEPTH, combinational
//   count       number of valid entries, 0..DEPTH
//   wrapped     sticky: an entry has been overwritten
//   dropped     saturating count of writes blocked by freeze
module debug_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wea,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] sel,
  input  logic              step_up,
  input  logic              step_dn,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] view_idx,
  output logic [ADDR_W:0]   count,
  output logic              wrapped,
  output logic [DROP_W-1:0] dropped
);

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_offset;
  logic              r_wrapped;
  logic [DROP_W-1:0] r_dropped;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic              w_store;
  logic              w_drop;
  logic              w_full;
  logic [ADDR_W-1:0] w_view_idx;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_view_valid;

  assign w_store      = wea & ~freeze & ~clr;
  assign w_drop       = wea &  freeze & ~clr;
  assign w_full       = (r_count == LP_FULL);
  // Both additions wrap naturally at ADDR_W bits, giving mod DEPTH.
  assign w_view_idx   = sel + r_offset;
  // Newest entry sits one slot behind the write pointer.
  assign w_rd_addr    = r_wr_ptr - ADDR_W'(1) - w_view_idx;
  assign w_view_valid = ({1'b0, w_view_idx} < r_count);

  // Trace storage; deliberately not reset, count alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && w_store) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Write pointer, fill count and wrap flag.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (w_store) begin
      r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_full) begin
        r_wrapped <= 1'b1;
      end else begin
        r_count <= r_count + (ADDR_W+1)'(1);
      end
    end
  end

  // Saturating counter of writes lost to freeze.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_dropped <= '0;
    end else if (w_drop && (r_dropped != {DROP_W{1'b1}})) begin
      r_dropped <= r_dropped + DROP_W'(1);
    end
  end

  // View offset; simultaneous up and down pulses cancel.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_offset <= '0;
    end else begin
      case ({step_up, step_dn})
        2'b10:   r_offset <= r_offset + ADDR_W'(1);
        2'b01:   r_offset <= r_offset - ADDR_W'(1);
        default: r_offset <= r_offset;
      endcase
    end
  end

  // Registered read port, reflecting pre-edge pointers and contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_view_valid;
      r_dout       <= w_view_valid ? r_mem[w_rd_addr] : '0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign view_idx   = w_view_idx;
  assign count      = r_count;
  assign wrapped    = r_wrapped;
  assign dropped    = r_dropped;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Testbench for debug_trace_buffer (DEPTH=4, DROP_W=2 build).
// Reference model: a queue of stored words with the newest at the front.
module tb_debug_trace_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int DROP_W = 2;
  localparam int DROP_MAX = 3;

  logic              clk;
  logic              rst;
  logic              wea;
  logic [DATA_W-1:0] din;
  logic              clr;
  logic              freeze;
  logic [ADDR_W-1:0] sel;
  logic              step_up;
  logic              step_dn;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W-1:0] view_idx;
  logic [ADDR_W:0]   count;
  logic              wrapped;
  logic [DROP_W-1:0] dropped;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [DATA_W-1:0] q[$];
  int  m_off  = 0;
  int  m_drop = 0;
  bit  m_wrap = 1'b0;

  debug_trace_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst), .wea(wea), .din(din), .clr(clr), .freeze(freeze),
    .sel(sel), .step_up(step_up), .step_dn(step_dn), .dout(dout),
    .dout_valid(dout_valid), .view_idx(view_idx), .count(count),
    .wrapped(wrapped), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, advance, update model, compare.
  task automatic step(input bit i_rst, input bit i_wea, input logic [31:0] i_din,
                      input bit i_clr, input bit i_frz, input int i_sel,
                      input bit i_up, input bit i_dn);
    int vi;
    bit e_val;
    logic [DATA_W-1:0] e_dout;
    rst = i_rst; wea = i_wea; din = i_din; clr = i_clr; freeze = i_frz;
    sel = ADDR_W'(i_sel); step_up = i_up; step_dn = i_dn;
    vi     = (i_sel + m_off) % DEPTH;
    e_val  = !i_rst && (vi < q.size());
    e_dout = e_val ? q[vi] : 32'h0;
    @(posedge clk);
    if (i_rst) begin
      q.delete(); m_off = 0; m_drop = 0; m_wrap = 1'b0;
    end else if (i_clr) begin
      q.delete(); m_off = 0; m_drop = 0; m_wrap = 1'b0;
    end else begin
      if (i_wea && !i_frz) begin
        if (q.size() == DEPTH) m_wrap = 1'b1;
        q.push_front(i_din);
        if (q.size() > DEPTH) void'(q.pop_back());
      end else if (i_wea && i_frz) begin
        if (m_drop < DROP_MAX) m_drop++;
      end
      if (i_up && !i_dn) m_off = (m_off + 1) % DEPTH;
      else if (i_dn && !i_up) m_off = (m_off + DEPTH - 1) % DEPTH;
    end
    #1;
    chk("dout",       64'(dout),       64'(e_dout));
    chk("dout_valid", 64'(dout_valid), 64'(e_val));
    chk("count",      64'(count),      64'(q.size()));
    chk("wrapped",    64'(wrapped),    64'(m_wrap));
    chk("dropped",    64'(dropped),    64'(m_drop));
    chk("view_idx",   64'(view_idx),   64'((i_sel + m_off) % DEPTH));
  endtask

  task automatic idle(input int i_sel);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, i_sel, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; wea = 1'b0; din = '0; clr = 1'b0; freeze = 1'b0;
    sel = '0; step_up = 1'b0; step_dn = 1'b0;
    #2;

    // reset state
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_valid", 64'(dout_valid), 64'h0);

    // three writes, read newest and oldest
    wr(32'h11); wr(32'h22); wr(32'h33);
    chk("tp1_count", 64'(count), 64'h3);
    idle(0);
    chk("tp1_newest", 64'(dout), 64'h33);
    chk("tp1_newest_v", 64'(dout_valid), 64'h1);
    idle(2);
    chk("tp1_oldest", 64'(dout), 64'h11);
    idle(3);
    chk("tp1_beyond_v", 64'(dout_valid), 64'h0);
    chk("tp1_beyond_d", 64'(dout), 64'h0);

    // wrap with 6 writes into 4 entries
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) wr(32'(i));
    chk("tp2_count", 64'(count), 64'h4);
    chk("tp2_wrapped", 64'(wrapped), 64'h1);
    for (int s = 0; s < 4; s++) begin
      idle(s);
      chk("tp2_age", 64'(dout), 64'(6 - s));
    end

    // freeze: counted, not stored, saturating
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("tp3_count", 64'(count), 64'h4);
    chk("tp3_dropped", 64'(dropped), 64'h3);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("tp3_sat", 64'(dropped), 64'h3);

    // stepping, including while frozen
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("tp4_up2", 64'(view_idx), 64'h2);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    chk("tp4_both", 64'(view_idx), 64'h2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    chk("tp4_dn3", 64'(view_idx), 64'h1);

    // clear with simultaneous write
    for (int i = 0; i < 5; i++) wr(32'h50 + 32'(i));
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h99, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("tp5_count", 64'(count), 64'h0);
    chk("tp5_wrapped", 64'(wrapped), 64'h0);
    chk("tp5_dropped", 64'(dropped), 64'h0);
    idle(0);
    chk("tp5_valid", 64'(dout_valid), 64'h0);
    wr(32'hAA);
    idle(0);
    chk("tp5_aa", 64'(dout), 64'hAA);

    // reset beats a concurrent write
    wr(32'h01);
    step(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("tp6_count", 64'(count), 64'h0);
    chk("tp6_dout", 64'(dout), 64'h0);
    idle(0);
    chk("tp6_valid", 64'(dout_valid), 64'h0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 70), $urandom,
           ($urandom_range(99) < 3), ($urandom_range(99) < 20),
           int'($urandom_range(DEPTH - 1)),
           ($urandom_range(99) < 25), ($urandom_range(99) < 25));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
